// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES encryption controller.
// DW/RW are fixed by the AES block format and are not meant to be overridden.
package aes_pkg;

  localparam int DW = 128;
  localparam int RW = 4;

  typedef enum logic [1:0] {
    AES128 = 2'b00,
    AES192 = 2'b01,
    AES256 = 2'b10
  } aes_mode_t;

  localparam logic [RW-1:0] NR_128 = 4'd10;
  localparam logic [RW-1:0] NR_192 = 4'd12;
  localparam logic [RW-1:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } ctrl_state_t;

  // Encoding 2'b11 is not a named mode; it falls through to the AES-256 count.
  function automatic logic [RW-1:0] nr_of(input aes_mode_t m);
    case (m)
      AES128:  return NR_128;
      AES192:  return NR_192;
      default: return NR_256;
    endcase
  endfunction

endpackage

// File: rtl/aes_rounddata.sv
// Combinational AES round: round 0 is a bare AddRoundKey, the last round skips
// MixColumns, every other round is SubBytes/ShiftRows/MixColumns/AddRoundKey.
module aes_rounddata
  import aes_pkg::*;
(
  input  logic [RW-1:0] round,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] state_in,
  input  logic [DW-1:0] round_key,
  output logic [DW-1:0] data_out
);

  logic [DW-1:0] sr_data;
  logic [DW-1:0] mc_data;
  logic [RW-1:0] last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse computed as b^254 (square-and-multiply), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] e;
    inv = 8'h01;
    e   = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (e[i]) inv = gf_mul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte i of the block is the i-th byte from the MSB; state[r][c] = byte r+4c.
  function automatic logic [7:0] byte_at(input logic [DW-1:0] x, input int i);
    return x[8*(15-i) +: 8];
  endfunction

  function automatic logic [DW-1:0] sub_shift(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[8*(15-(r+4*c)) +: 8] = sbox(byte_at(x, r + 4*((c + r) % 4)));
      end
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] mix_columns(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    logic [7:0] a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = byte_at(x, 4*c);
      a1 = byte_at(x, 4*c + 1);
      a2 = byte_at(x, 4*c + 2);
      a3 = byte_at(x, 4*c + 3);
      y[8*(15-4*c)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      y[8*(15-4*c-1)   +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      y[8*(15-4*c-2)   +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      y[8*(15-4*c-3)   +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return y;
  endfunction

  assign last_round = nr_of(aes_mode_t'(mode));
  assign sr_data    = sub_shift(state_in);
  assign mc_data    = mix_columns(sr_data);

  assign data_out = (round == '0)         ? (state_in ^ round_key) :
                    (round == last_round) ? (sr_data  ^ round_key) :
                                            (mc_data  ^ round_key);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption controller: one block in flight, one round per
// accepted round key, ciphertext held on a valid/ready port until taken.
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// ROUND | requesting key rk_round; a cycle with rk_valid advances one round
// DONE  | ciphertext presented; waiting for out_ready
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   data_in,
  output logic            rk_req,
  output logic [RW-1:0]   rk_round,
  input  logic            rk_valid,
  input  logic [DW-1:0]   round_key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   data_out,
  output logic            busy
);

  ctrl_state_t   state_q;
  aes_mode_t     mode_q;
  logic [DW-1:0] blk_q;
  logic [DW-1:0] rd_out;

  aes_rounddata u_rounddata (
    .round     (rk_round),
    .mode      (mode_q),
    .state_in  (blk_q),
    .round_key (round_key),
    .data_out  (rd_out)
  );

  // rk_round doubles as the round counter; all handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= AES128;
      blk_q     <= '0;
      rk_round  <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      rk_req    <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= ROUND;
            blk_q    <= data_in;
            mode_q   <= aes_mode_t'(mode);
            rk_round <= '0;
            rk_req   <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        ROUND: begin
          if (rk_valid) begin
            blk_q <= rd_out;
            if (rk_round == nr_of(mode_q)) begin
              state_q   <= DONE;
              data_out  <= rd_out;
              out_valid <= 1'b1;
              rk_req    <= 1'b0;
            end else begin
              rk_round <= rk_round + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
